// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the BCD to Excess-3 word sequencer.
package bcd_xs3_pkg;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bcd_illegal(input logic [DIGIT_W-1:0] digit);
    return (digit > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_excess3.sv
// Combinational single-digit BCD to Excess-3 converter (digit + 3, 4-bit wrap).
module bcd_to_excess3
  import bcd_xs3_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [DIGIT_W-1:0] excess3
);

  // Illegal inputs 10..15 wrap to 13,14,15,0,1,2; flagging is done by the caller.
  assign excess3 = bcd + XS3_OFFSET;

endmodule

// File: rtl/bcd_xs3_word_seq.sv
// Converts a packed BCD word to Excess-3 one digit per clock, LSB digit first,
// through a single shared converter, with valid/ready on both sides.
module bcd_xs3_word_seq
  import bcd_xs3_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int CNT_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NDIGITS-1:0]   in_bcd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_xs3,
  output logic [NDIGITS-1:0]     out_err,
  output logic                   busy
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_idx;
  logic [4*NDIGITS-1:0]   r_word;
  logic [4*NDIGITS-1:0]   r_xs3;
  logic [NDIGITS-1:0]     r_err;

  logic [DIGIT_W-1:0]     w_digits [NDIGITS];
  logic [DIGIT_W-1:0]     w_digit;
  logic [DIGIT_W-1:0]     w_digit_xs3;
  logic                   w_last;

  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_split
      assign w_digits[gi] = r_word[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  assign w_digit = w_digits[r_idx];
  assign w_last  = (r_idx == CNT_W'(NDIGITS - 1));

  bcd_to_excess3 u_conv (
    .bcd     (w_digit),
    .excess3 (w_digit_xs3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Results persist through DONE and IDLE; they are cleared only on a new capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
      r_xs3  <= '0;
      r_err  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_word <= in_bcd;
            r_xs3  <= '0;
            r_err  <= '0;
            r_idx  <= '0;
          end
        end
        CONV: begin
          for (int k = 0; k < NDIGITS; k++) begin
            if (r_idx == CNT_W'(k)) begin
              r_xs3[k*DIGIT_W +: DIGIT_W] <= w_digit_xs3;
              r_err[k]                    <= is_bcd_illegal(w_digit);
            end
          end
          r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_xs3 = r_xs3;
  assign out_err = r_err;

endmodule

// File: tb/tb_bcd_xs3_word_seq.sv
// Directed self-checking bench for bcd_xs3_word_seq with NDIGITS=4.
module tb_bcd_xs3_word_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_xs3;
  logic [3:0]  out_err;
  logic        busy;

  int total;
  int bad;
  int cyc;

  bcd_xs3_word_seq #(.NDIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xs3   (out_xs3),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Presents one word for one cycle and returns cycles until out_valid (-1 on timeout).
  task automatic drive_word(input logic [15:0] w, output int lat);
    @(negedge clk);
    in_bcd   = w;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (ok == 0) begin
      bad++;
      $display("FAIL %s: in_ready never returned high within 20 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bcd    = 16'h0;
    out_ready = 1'b0;
    #3;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_xs3 !== 16'h0 || out_err !== 4'h0) begin
      bad++;
      $display("FAIL reset: rdy/vld/busy=%b xs3=%h err=%b, want 100 0000 0000",
               {in_ready, out_valid, busy}, out_xs3, out_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    drive_word(16'h1234, lat);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL basic_latency: got %0d cycles, want 4", lat);
    end
    total++;
    if (out_xs3 !== 16'h4567 || out_err !== 4'b0000 || busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: xs3=%h err=%b busy=%b rdy=%b, want 4567 0000 1 0",
               out_xs3, out_err, busy, in_ready);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_xs3 !== 16'h4567) begin
      bad++;
      $display("FAIL basic_idle: vld=%b rdy=%b busy=%b xs3=%h, want 0 1 0 4567",
               out_valid, in_ready, busy, out_xs3);
    end
    $display("test_basic 1234 -> %h err=%b lat=%0d", out_xs3, out_err, lat);
  endtask

  task automatic test_illegal_digit();
    int lat;
    out_ready = 1'b1;
    drive_word(16'h9A05, lat);
    total++;
    if (lat !== 4 || out_xs3 !== 16'hCD38 || out_err !== 4'b0100) begin
      bad++;
      $display("FAIL illegal_digit: lat=%0d xs3=%h err=%b, want 4 cd38 0100", lat, out_xs3, out_err);
    end
    $display("test_illegal_digit 9A05 -> %h err=%b", out_xs3, out_err);
    wait_idle("illegal_digit_idle");
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    int seen;
    @(negedge clk);
    out_ready = 1'b1;
    in_bcd    = 16'h0000;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    in_bcd = 16'h9999;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (seen == 0 || out_xs3 !== 16'h3333 || out_err !== 4'b0000) begin
      bad++;
      $display("FAIL b2b_first: seen=%0d xs3=%h err=%b, want 1 3333 0000", seen, out_xs3, out_err);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        seen = 1;
        break;
      end
    end
    @(posedge clk);
    @(negedge clk);
    t1 = cyc;
    total++;
    if (seen == 0 || (t1 - t0) !== 6 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_spacing: seen=%0d spacing=%0d rdy=%b, want 1 6 0", seen, t1 - t0, in_ready);
    end
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (seen == 0 || out_xs3 !== 16'hCCCC || out_err !== 4'b0000) begin
      bad++;
      $display("FAIL b2b_second: seen=%0d xs3=%h err=%b, want 1 cccc 0000", seen, out_xs3, out_err);
    end
    $display("test_back_to_back 0000,9999 -> 3333,%h spacing=%0d", out_xs3, t1 - t0);
    wait_idle("b2b_idle");
  endtask

  task automatic test_backpressure();
    int lat;
    int stable_bad;
    out_ready = 1'b0;
    drive_word(16'h1234, lat);
    in_bcd   = 16'h5678;
    in_valid = 1'b1;
    total++;
    if (lat !== 4 || out_xs3 !== 16'h4567) begin
      bad++;
      $display("FAIL bp_first: lat=%0d xs3=%h, want 4 4567", lat, out_xs3);
    end
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_xs3 !== 16'h4567) stable_bad++;
    end
    total++;
    if (stable_bad != 0) begin
      bad++;
      $display("FAIL bp_stable: %0d unstable cycles (vld=%b rdy=%b xs3=%h), want 0",
               stable_bad, out_valid, in_ready, out_xs3);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    total++;
    if (lat !== 4 || out_xs3 !== 16'h89AB || out_err !== 4'b0000) begin
      bad++;
      $display("FAIL bp_second: lat=%0d xs3=%h err=%b, want 4 89ab 0000", lat, out_xs3, out_err);
    end
    $display("test_backpressure 1234 held, then 5678 -> %h", out_xs3);
    out_ready = 1'b1;
    wait_idle("bp_idle");
  endtask

  task automatic test_async_reset();
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_bcd    = 16'h1234;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_xs3 !== 16'h0 || out_err !== 4'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: vld=%b xs3=%h err=%b rdy=%b busy=%b, want 0 0000 0000 1 0",
               out_valid, out_xs3, out_err, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_word(16'h0815, lat);
    total++;
    if (lat !== 4 || out_xs3 !== 16'h3B48 || out_err !== 4'b0000) begin
      bad++;
      $display("FAIL after_reset: lat=%0d xs3=%h err=%b, want 4 3b48 0000", lat, out_xs3, out_err);
    end
    $display("test_async_reset then 0815 -> %h err=%b", out_xs3, out_err);
    wait_idle("after_reset_idle");
  endtask

  task automatic test_all_illegal();
    int lat;
    out_ready = 1'b1;
    drive_word(16'hFFFF, lat);
    total++;
    if (lat !== 4 || out_xs3 !== 16'h2222 || out_err !== 4'b1111) begin
      bad++;
      $display("FAIL all_illegal: lat=%0d xs3=%h err=%b, want 4 2222 1111", lat, out_xs3, out_err);
    end
    $display("test_all_illegal FFFF -> %h err=%b", out_xs3, out_err);
    wait_idle("all_illegal_idle");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    test_reset();
    test_basic();
    test_illegal_digit();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_all_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
